imem_prog_loader: RTL and testbench

- UART-driven instruction-memory loader that sits directly upstream of the reprogrammable fetch stage and the instruction memory.
- Consumes received UART bytes, parses a framed program image, and writes it into instruction memory as 32-bit words.
- Asserts memcon_prog_ena for the whole load, which holds fetch at PC 0 with the pipeline idle.
- Releases memcon_prog_ena only after a verified load, so fetch restarts cleanly from address 0.

---
 rtl/imem_prog_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// UART-framed program loader: parses SYNC/LEN/DATA/CHECKSUM frames into 32-bit instruction
// memory writes and holds fetch in program mode until the image checksum verifies.
module imem_prog_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        memcon_prog_ena,
    output logic [3:0]  imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        prog_done,
    output logic        prog_err,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t        state, next_state;
    logic [7:0]    len_lo;
    logic [15:0]   word_count;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   word_buf;
    logic [7:0]    checksum;
    logic [TW-1:0] tmo_cnt;

    logic [15:0]   len_full;
    logic [31:0]   shifted_word;
    logic          counting;
    logic          timed_out;
    logic          start_load;
    logic          last_word;

    always_comb begin
        len_full     = {rx_data, len_lo};
        shifted_word = {rx_data, word_buf[31:8]};
        counting     = (state == S_SYNC) || (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA) || (state == S_CHECK);
        // An arriving byte always beats a timeout landing in the same cycle.
        timed_out    = counting && !rx_valid && (tmo_cnt == TMO_LAST);
        start_load   = prog_req && ((state == S_IDLE) || (state == S_ERR));
        last_word    = (word_idx == word_count - 16'd1);
        next_state   = state;
        case (state)
            S_IDLE:   if (prog_req) next_state = S_SYNC;
            S_SYNC:   if (rx_valid && rx_data == SYNC_BYTE) next_state = S_LEN_LO;
            S_LEN_LO: if (rx_valid) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (rx_valid) begin
                    if ({16'd0, len_full} > $unsigned(MAX_WORDS)) next_state = S_ERR;
                    else if (len_full == 16'd0)                   next_state = S_CHECK;
                    else                                          next_state = S_DATA;
                end
            end
            S_DATA:   if (rx_valid && byte_idx == 2'd3 && last_word) next_state = S_CHECK;
            S_CHECK:  if (rx_valid) next_state = (rx_data == checksum) ? S_DONE : S_ERR;
            S_DONE:   next_state = S_IDLE;
            S_ERR:    if (prog_req) next_state = S_SYNC;
            default:  next_state = S_IDLE;
        endcase
        if (timed_out) next_state = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Datapath and registered outputs; the write for a word is issued the cycle after its 4th byte.
    always_ff @(posedge clk) begin
        if (Rst) begin
            memcon_prog_ena <= 1'b0;
            imem_we         <= 4'h0;
            imem_addr       <= 32'd0;
            imem_din        <= 32'd0;
            prog_done       <= 1'b0;
            prog_err        <= 1'b0;
            err_code        <= 2'b00;
            words_loaded    <= 16'd0;
            len_lo          <= 8'd0;
            word_count      <= 16'd0;
            word_idx        <= 16'd0;
            byte_idx        <= 2'd0;
            word_buf        <= 32'd0;
            checksum        <= 8'd0;
            tmo_cnt         <= '0;
        end else begin
            imem_we   <= 4'h0;
            prog_done <= 1'b0;

            if (!counting || rx_valid || next_state != state) tmo_cnt <= '0;
            else                                              tmo_cnt <= tmo_cnt + TW'(1);

            if (start_load) begin
                memcon_prog_ena <= 1'b1;
                prog_err        <= 1'b0;
                err_code        <= 2'b00;
                words_loaded    <= 16'd0;
                checksum        <= 8'd0;
                byte_idx        <= 2'd0;
                word_idx        <= 16'd0;
                word_count      <= 16'd0;
            end

            case (state)
                S_LEN_LO: if (rx_valid) len_lo <= rx_data;
                S_LEN_HI: begin
                    if (rx_valid) begin
                        word_count <= len_full;
                        if ({16'd0, len_full} > $unsigned(MAX_WORDS)) begin
                            prog_err <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        word_buf <= shifted_word;
                        checksum <= checksum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 4'hF;
                            imem_addr    <= {14'd0, word_idx, 2'b00};
                            imem_din     <= shifted_word;
                            words_loaded <= words_loaded + 16'd1;
                            word_idx     <= word_idx + 16'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == checksum) begin
                            prog_done       <= 1'b1;
                            memcon_prog_ena <= 1'b0;
                        end else begin
                            prog_err <= 1'b1;
                            err_code <= 2'b11;
                        end
                    end
                end
                default: ;
            endcase

            if (timed_out) begin
                prog_err <= 1'b1;
                err_code <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: directed frames plus randomized images compared
// against a frame-level reference model (expected writes, checksum and final status).
module tb_imem_prog_loader;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        Rst;
    logic        prog_req;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        memcon_prog_ena;
    logic [3:0]  imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        prog_done;
    logic        prog_err;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog_words[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [3:0]  cap_we[$];
    int          done_cnt = 0;
    int          done_ena_bad = 0;
    int          done_double = 0;
    bit          prev_done = 1'b0;

    always #5 clk = ~clk;

    imem_prog_loader #(
        .SYNC_BYTE(8'hA5),
        .MAX_WORDS(1024),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .Rst(Rst),
        .prog_req(prog_req),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .memcon_prog_ena(memcon_prog_ena),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_din(imem_din),
        .prog_done(prog_done),
        .prog_err(prog_err),
        .err_code(err_code),
        .words_loaded(words_loaded)
    );

    // Write and done-pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (imem_we !== 4'h0) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_din);
            cap_we.push_back(imem_we);
        end
        if (prog_done === 1'b1) begin
            done_cnt++;
            if (memcon_prog_ena !== 1'b0) done_ena_bad++;
            if (prev_done) done_double++;
        end
        prev_done = (prog_done === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic startLoad(input string tag);
        @(negedge clk);
        rx_valid = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        cap_we.delete();
        prog_req = 1'b1;
        @(negedge clk);
        prog_req = 1'b0;
        checkOutput({tag, "_ena_rise"}, memcon_prog_ena, 1);
        checkOutput({tag, "_err_clear"}, prog_err, 0);
        checkOutput({tag, "_code_clear"}, err_code, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ena"}, memcon_prog_ena, 0);
        checkOutput({tag, "_we"}, imem_we, 0);
        checkOutput({tag, "_addr"}, imem_addr, 0);
        checkOutput({tag, "_din"}, imem_din, 0);
        checkOutput({tag, "_done"}, prog_done, 0);
        checkOutput({tag, "_err"}, prog_err, 0);
        checkOutput({tag, "_code"}, err_code, 0);
        checkOutput({tag, "_words"}, words_loaded, 0);
    endtask

    // Builds the frame for prog_words, sends it, and checks the DUT against the frame-level model.
    task automatic runFrame(input string tag, input bit bad_cs, input bit garbage,
                            input bit strict, input bit poke_req, input int max_gap);
        logic [7:0] frame[$];
        logic [7:0] v;
        logic [7:0] cs;
        int n, sum, data_start, gap, dones0, last;
        n   = prog_words.size();
        sum = 0;
        frame = {};
        if (garbage) begin
            frame.push_back(8'h00);
            frame.push_back(8'hFF);
        end
        frame.push_back(8'hA5);
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        data_start = frame.size();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                v = 8'(prog_words[i] >> (8 * b));
                frame.push_back(v);
                sum += int'(v);
            end
        end
        cs = 8'(sum % 256);
        if (bad_cs) cs = cs - 8'd1;
        frame.push_back(cs);
        last = frame.size() - 1;

        startLoad(tag);
        dones0 = done_cnt;
        for (int k = 0; k <= last; k++) begin
            gap = strict ? 1 : $urandom_range(0, max_gap);
            applyStimulus(frame[k], gap);
            if (strict && k >= data_start && k < last)
                checkOutput({tag, "_we_lat"}, imem_we, (((k - data_start) % 4) == 3) ? 4'hF : 4'h0);
            if (strict && k == last) begin
                checkOutput({tag, "_done_lat"}, prog_done, bad_cs ? 0 : 1);
                checkOutput({tag, "_err_lat"}, prog_err, bad_cs ? 1 : 0);
            end
            if (poke_req && k == data_start) begin
                @(negedge clk);
                rx_valid = 1'b0;
                prog_req = 1'b1;
                @(negedge clk);
                prog_req = 1'b0;
                checkOutput({tag, "_poke_ena"}, memcon_prog_ena, 1);
            end
        end
        idleCycles(3);

        checkOutput({tag, "_nwrites"}, cap_addr.size(), n);
        for (int i = 0; i < n && i < cap_addr.size(); i++) begin
            checkOutput({tag, "_waddr"}, cap_addr[i], 4 * i);
            checkOutput({tag, "_wdata"}, cap_data[i], prog_words[i]);
            checkOutput({tag, "_wbe"}, cap_we[i], 4'hF);
        end
        checkOutput({tag, "_words"}, words_loaded, n);
        checkOutput({tag, "_dones"}, done_cnt - dones0, bad_cs ? 0 : 1);
        checkOutput({tag, "_err"}, prog_err, bad_cs ? 1 : 0);
        checkOutput({tag, "_code"}, err_code, bad_cs ? 2'b11 : 2'b00);
        checkOutput({tag, "_ena"}, memcon_prog_ena, bad_cs ? 1 : 0);
    endtask

    initial begin
        logic [31:0] w;
        int waited;

        Rst      = 1'b1;
        prog_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        Rst = 1'b0;
        idleCycles(2);

        $display("[TB] happy path");
        prog_words = {32'h0000_0013, 32'h0010_0093};
        runFrame("happy", 1'b0, 1'b1, 1'b1, 1'b0, 0);

        $display("[TB] zero length");
        prog_words = {};
        runFrame("zero", 1'b0, 1'b0, 1'b1, 1'b0, 0);

        $display("[TB] bad checksum");
        prog_words = {32'h0000_0013, 32'h0010_0093};
        runFrame("badcs", 1'b1, 1'b0, 1'b1, 1'b0, 0);

        $display("[TB] oversize");
        startLoad("over");
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h04, 1);
        checkOutput("over_err", prog_err, 1);
        checkOutput("over_code", err_code, 2'b01);
        idleCycles(3);
        checkOutput("over_ena", memcon_prog_ena, 1);
        checkOutput("over_nwrites", cap_addr.size(), 0);

        $display("[TB] timeout");
        startLoad("tmo");
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h13, 1);
        idleCycles(TMO / 2);
        checkOutput("tmo_early", prog_err, 0);
        waited = 0;
        while (prog_err !== 1'b1 && waited < 3 * TMO) begin
            idleCycles(1);
            waited++;
        end
        checkOutput("tmo_flag", prog_err, 1);
        checkOutput("tmo_code", err_code, 2'b10);
        checkOutput("tmo_nwrites", cap_addr.size(), 0);
        checkOutput("tmo_ena", memcon_prog_ena, 1);

        $display("[TB] prog_req during data");
        prog_words = {};
        for (int i = 0; i < 3; i++) prog_words.push_back($urandom);
        runFrame("poke", 1'b0, 1'b0, 1'b0, 1'b1, 2);

        $display("[TB] reset mid-load");
        startLoad("rst");
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h03, 1);
        applyStimulus(8'h00, 1);
        w = $urandom;
        for (int b = 0; b < 4; b++) applyStimulus(8'(w >> (8 * b)), 1);
        checkOutput("rst_we_pre", imem_we, 4'hF);
        checkOutput("rst_din_pre", imem_din, w);
        checkOutput("rst_words_pre", words_loaded, 1);
        @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        checkAllZero("rst");
        cap_addr.delete();
        cap_data.delete();
        cap_we.delete();
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h01, 1);
        applyStimulus(8'h00, 1);
        for (int b = 0; b < 5; b++) applyStimulus(8'h11, 1);
        idleCycles(3);
        checkOutput("idle_ena", memcon_prog_ena, 0);
        checkOutput("idle_nwrites", cap_addr.size(), 0);
        checkOutput("idle_words", words_loaded, 0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            prog_words = {};
            for (int i = 0; i < $urandom_range(1, 6); i++) prog_words.push_back($urandom);
            runFrame("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 1'b0, 1'b0, 3);
        end

        checkOutput("done_single_cycle", done_double, 0);
        checkOutput("done_with_ena_low", done_ena_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
